// File: rtl/cam_frame_capture.sv
// cam_frame_capture: captures a byte-serial RGB565 camera stream into a cropped frame buffer
// and serves registered pixel reads to the OLED scan driver.
module cam_frame_capture #(
  parameter int C_x_size   = 128,
  parameter int C_y_size   = 128,
  parameter int C_x_offset = 16,
  parameter int C_y_offset = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cam_vsync,
  input  logic                        cam_href,
  input  logic                        cam_de,
  input  logic [7:0]                  cam_data,
  input  logic                        freeze,
  input  logic [$clog2(C_x_size)-1:0] x,
  input  logic [$clog2(C_y_size)-1:0] y,
  output logic [15:0]                 color,
  output logic                        frame_done,
  output logic [7:0]                  frame_count
);
  localparam int XW = $clog2(C_x_size);
  localparam int YW = $clog2(C_y_size);
  localparam int CW = 11;
  localparam logic [CW-1:0] XO = CW'(C_x_offset);
  localparam logic [CW-1:0] YO = CW'(C_y_offset);
  localparam logic [CW-1:0] XS = CW'(C_x_size);
  localparam logic [CW-1:0] YS = CW'(C_y_size);
  typedef enum logic [1:0] {IDLE, WAIT_LINE, LINE, SKIP} state_t;
  state_t            state_q, state_d;
  logic              vs_q, vs_prev_q, vs_edge;
  logic [CW-1:0]     col_q, col_d, row_q, row_d, cx, ry;
  logic              phase_q, phase_d, in_win;
  logic [7:0]        hi_q, hi_d, frame_count_q, frame_count_d;
  logic              wr_en_q, wr_en_d, frame_done_q, frame_done_d;
  logic [XW+YW-1:0]  wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d, color_q, color_d;
  logic [15:0]       mem [C_x_size*C_y_size];
  // out-of-window coordinates wrap to large unsigned values, so one compare per axis suffices
  assign cx      = col_q - XO;
  assign ry      = row_q - YO;
  assign in_win  = (cx < XS) && (ry < YS);
  assign vs_edge = vs_q & ~vs_prev_q;
  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    phase_d       = phase_q;
    hi_d          = hi_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    color_d       = mem[{y, x}];
    if (state_q == IDLE || state_q == SKIP) begin
      if (vs_edge) begin
        state_d = (state_q == SKIP) ? IDLE : (freeze ? SKIP : WAIT_LINE);
        col_d   = '0;
        row_d   = '0;
        phase_d = 1'b0;
      end
    end else if (vs_edge) begin
      frame_done_d  = 1'b1;
      frame_count_d = frame_count_q + 8'd1;
      state_d       = freeze ? SKIP : WAIT_LINE;
      col_d         = '0;
      row_d         = '0;
      phase_d       = 1'b0;
    end else if (state_q == WAIT_LINE) begin
      if (cam_href) begin
        state_d = LINE;
        col_d   = '0;
        phase_d = 1'b0;
      end
    end else if (!cam_href) begin
      state_d = WAIT_LINE;
      row_d   = &row_q ? row_q : row_q + 1'b1;
      phase_d = 1'b0;
    end else if (cam_de) begin
      phase_d = ~phase_q;
      hi_d    = phase_q ? hi_q : cam_data;
      if (phase_q) begin
        wr_en_d   = in_win;
        wr_addr_d = {ry[YW-1:0], cx[XW-1:0]};
        wr_data_d = {hi_q, cam_data};
        col_d     = &col_q ? col_q : col_q + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      vs_q          <= 1'b0;
      vs_prev_q     <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
      phase_q       <= 1'b0;
      hi_q          <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      color_q       <= '0;
    end else begin
      state_q       <= state_d;
      vs_q          <= cam_vsync;
      vs_prev_q     <= vs_q;
      col_q         <= col_d;
      row_q         <= row_d;
      phase_q       <= phase_d;
      hi_q          <= hi_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      color_q       <= color_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en_q) mem[wr_addr_q] <= wr_data_q;
  end
  assign color       = color_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
endmodule
